// File: rtl/afe_sync_pkg.sv
// Shared constants for the AFE sync sequencer: FSM state encoding,
// default parameter values and the channel-index width helper.
package afe_sync_pkg;

    localparam int CNT_W_DEF = 20;
    localparam int N_CH_DEF  = 4;
    localparam int PW_W_DEF  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_PULSE = 3'd2,
        S_GAP   = 3'd3,
        S_HOLD  = 3'd4
    } afe_state_t;

    // A single channel still needs a 1-bit index.
    function automatic int idx_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/afe_sync_seq_if.sv
// Configuration and status bundle between the AFE sync sequencer and its controller.
interface afe_sync_seq_if
    import afe_sync_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int N_CH  = N_CH_DEF,
    parameter int PW_W  = PW_W_DEF
);

    // No valid/ready pair: enable is a level. Raising it captures every config
    // field on the next edge; lowering it aborts and re-arms on the next edge.
    logic              enable;
    logic [CNT_W-1:0]  delay;
    logic [PW_W-1:0]   pulse_width;
    logic [PW_W-1:0]   stagger;
    logic              periodic;
    logic [CNT_W-1:0]  period;
    logic [N_CH-1:0]   sync;
    logic              busy;
    logic              seq_done;

    modport master (
        output enable, delay, pulse_width, stagger, periodic, period,
        input  sync, busy, seq_done
    );

    modport slave (
        input  enable, delay, pulse_width, stagger, periodic, period,
        output sync, busy, seq_done
    );

endinterface

// File: rtl/afe_down_counter.sv
// Loadable down counter that sticks at zero instead of wrapping.
module afe_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/afe_sync_seq.sv
// AFE sync sequencer: after a start delay, pulses each sync channel in turn,
// optionally repeating every period. All outputs are registered off the FSM.
module afe_sync_seq
    import afe_sync_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int N_CH  = N_CH_DEF,
    parameter int PW_W  = PW_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    afe_sync_seq_if.slave     bus,
    output afe_state_t        dbg_state,
    output logic [CNT_W-1:0]  dbg_wait_cnt
);

    localparam int IDX_W = idx_width(N_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    afe_state_t       state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             done_q, done_nxt;
    logic             capture;

    // The wait counter doubles as the captured copy of delay.
    logic [PW_W-1:0]  sh_pw;
    logic [PW_W-1:0]  sh_stagger;
    logic             sh_periodic;
    logic [CNT_W-1:0] sh_period;

    logic             wcnt_load, wcnt_dec, wcnt_zero;
    logic [CNT_W-1:0] wcnt_val, wcnt_count;
    logic             pcnt_load, pcnt_dec, pcnt_zero, pcnt_last;
    logic [PW_W-1:0]  pcnt_val, pcnt_count;

    logic [N_CH-1:0]  sync_dec;
    logic [N_CH-1:0]  sync_q;
    logic             busy_q;
    logic             seq_done_q;

    afe_down_counter #(.W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (wcnt_load),
        .dec      (wcnt_dec),
        .load_val (wcnt_val),
        .count    (wcnt_count),
        .zero     (wcnt_zero)
    );

    afe_down_counter #(.W(PW_W)) u_pulse_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (pcnt_load),
        .dec      (pcnt_dec),
        .load_val (pcnt_val),
        .count    (pcnt_count),
        .zero     (pcnt_zero)
    );

    // Pulse/gap counters hold the remaining cycles including the current one.
    assign pcnt_last = pcnt_zero || (pcnt_count == PW_W'(1));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        capture   = 1'b0;
        wcnt_load = 1'b0;
        wcnt_dec  = 1'b0;
        wcnt_val  = bus.delay;
        pcnt_load = 1'b0;
        pcnt_dec  = 1'b0;
        pcnt_val  = sh_pw;
        if (!bus.enable) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    capture   = 1'b1;
                    wcnt_load = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (wcnt_zero) begin
                        pcnt_load = 1'b1;
                        state_nxt = S_PULSE;
                    end else begin
                        wcnt_dec = 1'b1;
                    end
                end
                S_PULSE: begin
                    if (!pcnt_last) begin
                        pcnt_dec = 1'b1;
                    end else if (idx == LAST_IDX) begin
                        done_nxt = 1'b1;
                        idx_nxt  = '0;
                        if (sh_periodic) begin
                            wcnt_load = 1'b1;
                            wcnt_val  = sh_period;
                            state_nxt = S_WAIT;
                        end else begin
                            state_nxt = S_HOLD;
                        end
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        pcnt_load = 1'b1;
                        if (sh_stagger == '0) begin
                            state_nxt = S_PULSE;
                        end else begin
                            pcnt_val  = sh_stagger;
                            state_nxt = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (pcnt_last) begin
                        pcnt_load = 1'b1;
                        state_nxt = S_PULSE;
                    end else begin
                        pcnt_dec = 1'b1;
                    end
                end
                S_HOLD: state_nxt = S_HOLD;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            done_q      <= 1'b0;
            sh_pw       <= '0;
            sh_stagger  <= '0;
            sh_periodic <= 1'b0;
            sh_period   <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            done_q <= done_nxt;
            if (capture) begin
                sh_pw       <= (bus.pulse_width == '0) ? PW_W'(1) : bus.pulse_width;
                sh_stagger  <= bus.stagger;
                sh_periodic <= bus.periodic;
                sh_period   <= bus.period;
            end
        end
    end

    always_comb begin
        sync_dec = '0;
        for (int i = 0; i < N_CH; i++) begin
            sync_dec[i] = (state == S_PULSE) && (idx == IDX_W'(i));
        end
    end

    // Output stage lags the FSM by one edge; dropping enable clears it at once.
    always_ff @(posedge clk) begin
        if (!reset_n || !bus.enable) begin
            sync_q     <= '0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            sync_q     <= sync_dec;
            busy_q     <= (state == S_WAIT) || (state == S_PULSE) || (state == S_GAP);
            seq_done_q <= done_q;
        end
    end

    assign bus.sync      = sync_q;
    assign bus.busy      = busy_q;
    assign bus.seq_done  = seq_done_q;
    assign dbg_state     = state;
    assign dbg_wait_cnt  = wcnt_count;

endmodule

// File: tb/tb_afe_sync_seq.sv
// Directed bench for afe_sync_seq: edge-by-edge comparison of sync/busy/seq_done
// against a timing model built from the documented edge numbers.
`timescale 1ns/1ps
module tb_afe_sync_seq;
    import afe_sync_pkg::*;

    localparam int CNT_W = 20;
    localparam int PW_W  = 8;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    afe_sync_seq_if #(.CNT_W(CNT_W), .N_CH(4), .PW_W(PW_W)) bus0();
    afe_sync_seq_if #(.CNT_W(CNT_W), .N_CH(1), .PW_W(PW_W)) bus1();

    afe_state_t       st0, st1;
    logic [CNT_W-1:0] wc0, wc1;

    afe_sync_seq #(.CNT_W(CNT_W), .N_CH(4), .PW_W(PW_W)) dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus0),
        .dbg_state    (st0),
        .dbg_wait_cnt (wc0)
    );

    afe_sync_seq #(.CNT_W(CNT_W), .N_CH(1), .PW_W(PW_W)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus1),
        .dbg_state    (st1),
        .dbg_wait_cnt (wc1)
    );

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected {seq_done, busy, sync[n-1:0]} at edge k (edge 0 samples enable=1).
    function automatic logic [31:0] model_exp(input int k, input int dly, input int pw,
                                              input int stg, input int per,
                                              input bit periodic, input int n);
        int pwe;
        int start0;
        int len;
        int slot;
        int t;
        logic [31:0] e;
        pwe    = (pw == 0) ? 1 : pw;
        start0 = dly + 2;
        len    = n * pwe + (n - 1) * stg;
        slot   = pwe + stg;
        t      = k - start0;
        e      = '0;
        e[n]   = (k >= 1);
        if (t >= 0) begin
            if (periodic) t = t % (len + per + 1);
            else if (t >= len) e[n] = 1'b0;
            if (t < len && (t % slot) < pwe) e[t / slot] = 1'b1;
            if (t == len) e[n + 1] = 1'b1;
        end
        return e;
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg0(input int dly, input int pw, input int stg, input int per, input bit periodic);
        bus0.delay       = CNT_W'(dly);
        bus0.pulse_width = PW_W'(pw);
        bus0.stagger     = PW_W'(stg);
        bus0.period      = CNT_W'(per);
        bus0.periodic    = periodic;
    endtask

    task automatic rearm();
        bus0.enable = 1'b0;
        bus1.enable = 1'b0;
        repeat (2) step();
    endtask

    // Caller raises enable just after an edge; the next edge is edge 0.
    task automatic run_seq(input string tag, input int n_edges, input int dly, input int pw,
                           input int stg, input int per, input bit periodic,
                           input bit use1, input int chg_at);
        logic [31:0] got;
        for (int k = 0; k < n_edges; k++) begin
            step();
            if (use1) got = {29'b0, bus1.seq_done, bus1.busy, bus1.sync};
            else      got = {26'b0, bus0.seq_done, bus0.busy, bus0.sync};
            exp_q.push_back(model_exp(k, dly, pw, stg, per, periodic, use1 ? 1 : 4));
            check_val($sformatf("%s@%0d", tag, k), got, exp_q.pop_front());
            if (!use1 && k == 0) check_val($sformatf("%s.wait_cnt@0", tag), 32'(wc0), 32'(dly));
            if (k == chg_at) begin
                bus0.delay       = CNT_W'(1);
                bus0.pulse_width = PW_W'(7);
                bus0.stagger     = PW_W'(3);
                bus0.periodic    = 1'b1;
                bus0.period      = CNT_W'(2);
            end
        end
    endtask

    initial begin
        bus0.enable = 1'b0;
        bus1.enable = 1'b0;
        cfg0(0, 0, 0, 0, 1'b0);
        bus1.delay = '0; bus1.pulse_width = '0; bus1.stagger = '0;
        bus1.period = '0; bus1.periodic = 1'b0;

        // reset state, with enable high to show reset wins
        reset_n = 1'b0;
        bus0.enable = 1'b1;
        repeat (3) step();
        check_val("rst.out0", {26'b0, bus0.seq_done, bus0.busy, bus0.sync}, 32'h0);
        check_val("rst.state0", 32'(st0), 32'(S_IDLE));
        check_val("rst.wcnt0", 32'(wc0), 32'h0);
        check_val("rst.out1", {29'b0, bus1.seq_done, bus1.busy, bus1.sync}, 32'h0);
        check_val("rst.state1", 32'(st1), 32'(S_IDLE));
        bus0.enable = 1'b0;
        reset_n = 1'b1;
        repeat (2) step();

        // one-shot: sync[0] 7-9 ... sync[3] 22-24, seq_done 25, then HOLD
        cfg0(5, 3, 2, 0, 1'b0);
        bus0.enable = 1'b1;
        run_seq("oneshot", 31, 5, 3, 2, 0, 1'b0, 1'b0, -1);
        check_val("oneshot.hold", 32'(st0), 32'(S_HOLD));
        rearm();

        // periodic: sync 4-7, seq_done 8, next sync[0] at 19, three rounds
        cfg0(2, 1, 0, 10, 1'b1);
        bus0.enable = 1'b1;
        run_seq("periodic", 52, 2, 1, 0, 10, 1'b1, 1'b0, -1);
        rearm();

        // abort while sync[2] is high (edge 17), then restart
        cfg0(5, 3, 2, 0, 1'b0);
        bus0.enable = 1'b1;
        run_seq("abort_pre", 18, 5, 3, 2, 0, 1'b0, 1'b0, -1);
        bus0.enable = 1'b0;
        step();
        check_val("abort.out", {26'b0, bus0.seq_done, bus0.busy, bus0.sync}, 32'h0);
        check_val("abort.state", 32'(st0), 32'(S_IDLE));
        step();
        check_val("abort.quiet", {26'b0, bus0.seq_done, bus0.busy, bus0.sync}, 32'h0);
        bus0.enable = 1'b1;
        run_seq("restart", 27, 5, 3, 2, 0, 1'b0, 1'b0, -1);
        rearm();

        // degenerate: N_CH=1, delay=0, pulse_width=0
        bus1.enable = 1'b1;
        run_seq("degen", 8, 0, 0, 0, 0, 1'b0, 1'b1, -1);
        check_val("degen.hold", 32'(st1), 32'(S_HOLD));
        rearm();

        // reset mid-WAIT, then restart on release
        cfg0(5, 3, 2, 0, 1'b0);
        bus0.enable = 1'b1;
        run_seq("rst_pre", 3, 5, 3, 2, 0, 1'b0, 1'b0, -1);
        reset_n = 1'b0;
        step();
        check_val("midrst.out", {26'b0, bus0.seq_done, bus0.busy, bus0.sync}, 32'h0);
        check_val("midrst.state", 32'(st0), 32'(S_IDLE));
        check_val("midrst.wcnt", 32'(wc0), 32'h0);
        reset_n = 1'b1;
        run_seq("rst_post", 27, 5, 3, 2, 0, 1'b0, 1'b0, -1);
        rearm();

        // inputs changed after capture (edge 1) must not affect this run
        cfg0(5, 2, 0, 0, 1'b0);
        bus0.enable = 1'b1;
        run_seq("capture", 26, 5, 2, 0, 0, 1'b0, 1'b0, 1);
        check_val("capture.hold", 32'(st0), 32'(S_HOLD));
        rearm();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
